uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 69 ++++++
 tb/tb_uart_tx_serializer.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with internal baud-period and bit counters
module uart_tx_serializer #(
  parameter int BAUD_WIDTH      = 13,
  parameter int BAUD_TICK_COUNT = 5208,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int BIT_W = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state_q, state_d;
  logic [BAUD_WIDTH-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic serial_q, serial_d, busy_q, busy_d, done_q, done_d;
  logic tick, last;
  always_comb begin
    tick = baud_q == BAUD_WIDTH'(BAUD_TICK_COUNT - 1);
    last = bit_q == BIT_W'(DATA_BITS - 1);
    state_d = state_q;
    baud_d = (state_q == IDLE || tick) ? '0 : baud_q + BAUD_WIDTH'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    if (state_q == IDLE) begin
      if (tx_start) begin
        state_d = START;
        shift_d = tx_data;
        bit_d = '0;
      end
    end else if (tick) begin
      state_d = state_q == START ? DATA : state_q == STOP ? IDLE : last ? STOP : DATA;
      if (state_q == DATA) begin
        shift_d = shift_q >> 1;
        bit_d = last ? '0 : bit_q + BIT_W'(1);
      end
    end
    serial_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = state_q == STOP && tick;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      serial_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      serial_q <= serial_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx_serial = serial_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer against a frame-timing model
module tb_uart_tx_serializer;
  localparam int T = 4;
  localparam int F = 10 * T;
  localparam int TB = 5208;
  localparam int FB = 10 * TB;
  typedef struct {
    logic [7:0] d;
    int acc;
  } fr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, start_a = 1'b0, ser_a, busy_a, done_a;
  logic rst_b = 1'b1, start_b = 1'b0, ser_b, busy_b, done_b;
  logic [7:0] data_a = '0, data_b = '0;
  int passed = 0, total = 0;
  int e = 0, last_acc = -1000, k_m;
  logic cur_v = 1'b0, chk = 1'b0;
  fr_t cur, f;
  fr_t q[$];
  logic hist[int];
  logic [7:0] got;
  uart_tx_serializer #(.BAUD_WIDTH(3), .BAUD_TICK_COUNT(T), .DATA_BITS(8)) dut_a (
    .clk(clk), .reset(rst_a), .tx_start(start_a), .tx_data(data_a),
    .tx_serial(ser_a), .tx_busy(busy_a), .tx_done(done_a)
  );
  uart_tx_serializer dut_b (
    .clk(clk), .reset(rst_b), .tx_start(start_b), .tx_data(data_b),
    .tx_serial(ser_b), .tx_busy(busy_b), .tx_done(done_b)
  );
  function automatic void check(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction
  function automatic logic bit_at(logic [7:0] d, int k, int t);
    int i;
    i = k / t;
    return i == 0 ? 1'b0 : i <= 8 ? d[i-1] : 1'b1;
  endfunction
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    e++;
    if (rst_a) begin
      cur_v = 1'b0;
      last_acc = -1000;
      q.delete();
    end else if (start_a && e >= last_acc + F + 1) begin
      last_acc = e;
      cur = '{data_a, e};
      cur_v = 1'b1;
      q.push_back(cur);
    end
  end
  always @(negedge clk) if (chk) begin
    k_m = e - last_acc;
    hist[e] = ser_a;
    check("busy", busy_a, int'(cur_v && k_m < F));
    check("done", done_a, int'(cur_v && k_m == F));
    check("serial", ser_a, (cur_v && k_m < F) ? bit_at(cur.d, k_m, T) : 1'b1);
    if (done_a) begin
      check("done_pending", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        f = q.pop_front();
        check("frame_len", e - f.acc, F);
        for (int i = 0; i < 8; i++) got[i] = hist[f.acc + T * (i + 1) + T / 2];
        check("frame_byte", got, f.d);
      end
    end
  end
  initial begin
    int h;
    step(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk = 1'b1;
    step(100);
    data_a = 8'hA5; start_a = 1'b1; step(1); start_a = 1'b0; step(45);
    data_a = 8'h00; start_a = 1'b1; step(1); data_a = 8'hFF; step(85); start_a = 1'b0; step(5);
    data_a = 8'h3C; start_a = 1'b1; step(1); start_a = 1'b0; step(15);
    data_a = 8'hFF; start_a = 1'b1; step(1); start_a = 1'b0; step(40);
    data_a = 8'h55; start_a = 1'b1; step(1); start_a = 1'b0; step(16);
    rst_a = 1'b1; step(1); rst_a = 1'b0; step(3);
    data_a = 8'h81; start_a = 1'b1; step(1); start_a = 1'b0; step(45);
    for (int n = 0; n < 12; n++) begin
      data_a = 8'($urandom);
      start_a = 1'b1;
      h = $urandom_range(1, 50);
      repeat (h) begin
        step(1);
        data_a = 8'($urandom);
      end
      start_a = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        rst_a = 1'b1; step(1); rst_a = 1'b0;
      end
      step($urandom_range(0, 45));
    end
    step(50);
    check("queue_drained", q.size(), 0);
    data_b = 8'h41; start_b = 1'b1; step(1); start_b = 1'b0;
    for (int k = 0; k <= FB + 1; k++) begin
      @(negedge clk);
      if (k < FB && (k % TB == 0 || k % TB == TB / 2 || k % TB == TB - 1))
        check("slow_serial", ser_b, bit_at(8'h41, k, TB));
      if (k >= FB - 1) begin
        check("slow_done", done_b, int'(k == FB));
        check("slow_busy", busy_b, int'(k < FB));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
